fetch_stage: RTL

//  IF stage of the 5-stage MIPS pipeline: owns the PC, issues word fetches to instruction

---
 rtl/mips_pkg.sv | 19 +
 rtl/fetch_stage_if.sv | 12 +
 rtl/fetch_skid_buf.sv | 50 +++++
 rtl/fetch_stage.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and the fetch-stage state encoding for the MIPS pipeline.
package mips_pkg;

   // sll $0,$0,0 -- the canonical bubble
   localparam logic [31:0] NOP_INST = 32'h0000_0000;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,   // request outstanding, results delivered
      ST_DRAIN = 2'd1,   // stale request outstanding, result thrown away
      ST_HOLD  = 2'd2    // skid full, waiting for the stall to clear
   } fetch_state_e;

   // Instruction fetches are always word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & ~32'h3;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus seen by the fetch stage.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr,
                   input  imem_ack, input  imem_rdata);
   modport slave  (input  imem_req, input  imem_addr,
                   output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {pcplus4, inst} buffer that catches an instruction accepted
// from memory while the decode stage is stalled.
module fetch_skid_buf (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] in_pcplus4,
   input  logic [31:0] in_inst,
   output logic        full,
   output logic [31:0] out_pcplus4,
   output logic [31:0] out_inst
);
   import mips_pkg::*;

   logic        full_q, full_d;
   logic [31:0] pcplus4_q, pcplus4_d;
   logic [31:0] inst_q, inst_d;

   // Clear wins over load; a flush must never leave a stale entry behind.
   always_comb begin
      full_d    = full_q;
      pcplus4_d = pcplus4_q;
      inst_d    = inst_q;
      if (clear) begin
         full_d = 1'b0;
      end else if (load) begin
         full_d    = 1'b1;
         pcplus4_d = in_pcplus4;
         inst_d    = in_inst;
      end
   end

   // Buffer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         full_q    <= 1'b0;
         pcplus4_q <= 32'h0;
         inst_q    <= NOP_INST;
      end else begin
         full_q    <= full_d;
         pcplus4_q <= pcplus4_d;
         inst_q    <= inst_d;
      end
   end

   assign full        = full_q;
   assign out_pcplus4 = pcplus4_q;
   assign out_inst    = inst_q;
endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the fetch address, talks to instruction memory over a
// req/ack handshake and feeds {pcplus4, inst, valid} to the IF/ID register.
// Stalls are absorbed by a one-entry skid buffer; redirects flush the stage
// and, if a request is still unacknowledged, drain it before re-targeting.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC_P = mips_pkg::RESET_PC,
   parameter logic [31:0] NOP_INST_P = mips_pkg::NOP_INST
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_f,
   input  logic            redirect,
   input  logic [31:0]     redirect_pc,
   fetch_stage_if.master   imem,
   output logic [31:0]     out_pcplus4,
   output logic [31:0]     out_inst,
   output logic            out_valid
);

   fetch_state_e state_q, state_d;
   logic         req_q, req_d;
   logic [31:0]  addr_q, addr_d;
   logic [31:0]  target_q, target_d;
   logic [31:0]  pcplus4_q, pcplus4_d;
   logic [31:0]  inst_q, inst_d;
   logic         valid_q, valid_d;

   logic         skid_load, skid_clear, skid_full;
   logic [31:0]  skid_pcplus4, skid_inst;
   logic         accepted;
   logic [31:0]  redirect_tgt;
   logic [31:0]  addr_plus4;

   // An ack only counts while a request is actually being presented.
   assign accepted     = imem.imem_ack & req_q;
   assign redirect_tgt = word_align(redirect_pc);
   assign addr_plus4   = addr_q + 32'd4;

   fetch_skid_buf u_skid (
      .clk         (clk),
      .reset       (reset),
      .load        (skid_load),
      .clear       (skid_clear),
      .in_pcplus4  (addr_plus4),
      .in_inst     (imem.imem_rdata),
      .full        (skid_full),
      .out_pcplus4 (skid_pcplus4),
      .out_inst    (skid_inst)
   );

   // Next-state, address and output-register logic.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      target_d   = target_q;
      pcplus4_d  = pcplus4_q;
      inst_d     = inst_q;
      valid_d    = valid_q;
      skid_load  = 1'b0;
      skid_clear = 1'b0;

      if (redirect) begin
         // Flush: bubble out, drop any buffered instruction.
         valid_d    = 1'b0;
         inst_d     = NOP_INST_P;
         skid_clear = 1'b1;
      end

      case (state_q)
         ST_FETCH: begin
            if (redirect) begin
               // The handshake is never retracted: an unacked request must
               // complete before the new target can be presented.
               if (req_q && !accepted) begin
                  target_d = redirect_tgt;
                  state_d  = ST_DRAIN;
               end else begin
                  addr_d = redirect_tgt;
               end
            end else if (accepted) begin
               addr_d = addr_plus4;
               if (stall_f) begin
                  skid_load = 1'b1;
                  state_d   = ST_HOLD;
               end else begin
                  pcplus4_d = addr_plus4;
                  inst_d    = imem.imem_rdata;
                  valid_d   = 1'b1;
               end
            end else if (!stall_f) begin
               valid_d = 1'b0;
               inst_d  = NOP_INST_P;
            end
         end
         ST_DRAIN: begin
            if (redirect) begin
               if (accepted) begin
                  addr_d  = redirect_tgt;
                  state_d = ST_FETCH;
               end else begin
                  target_d = redirect_tgt;
               end
            end else if (accepted) begin
               addr_d  = target_q;
               state_d = ST_FETCH;
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               addr_d  = redirect_tgt;
               state_d = ST_FETCH;
            end else if (!stall_f && skid_full) begin
               pcplus4_d  = skid_pcplus4;
               inst_d     = skid_inst;
               valid_d    = 1'b1;
               skid_clear = 1'b1;
               state_d    = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase

      // The request line is registered: it is presented in every state
      // except while waiting on a full skid buffer.
      req_d = (state_d != ST_HOLD);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_FETCH;
         req_q     <= 1'b0;
         addr_q    <= RESET_PC_P;
         target_q  <= RESET_PC_P;
         pcplus4_q <= 32'h0;
         inst_q    <= NOP_INST_P;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         target_q  <= target_d;
         pcplus4_q <= pcplus4_d;
         inst_q    <= inst_d;
         valid_q   <= valid_d;
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = addr_q;
   assign out_pcplus4    = pcplus4_q;
   assign out_inst       = inst_q;
   assign out_valid      = valid_q;
endmodule
